tree_level_stage_mp: RTL and testbench
======================================

// Module: tree_level_stage_mp
// PURPOSE
//  Generic classification-tree level for the FPGA packet classifier. LANES independent lookup lanes share one node table.
//  Per lane: pick up to EBITS header bits at positions named by the current node, add the masked index to the child base,
//  fetch the child node. Leaf (matched) nodes pass through unchanged. Adds a runtime table-update port and address checking.
//  Sits between successive tree levels; chained LEVELS deep from root to leaf stage.
// PARAMETERS
//  PACKET_WIDTH 104  header width
//  NODE_WIDTH   40   node word width
//  LANES        2    parallel lookup lanes (1..4)
//  EBITS        3    extracted bits per node (1..3); child index width
//  BIT_WIDTH    8    width of each bit-position field
//  NODE_ADDR    9    child base address width, node[NODE_WIDTH-1 -: NODE_ADDR]
//  MEM_DEPTH    64   node table entries (<= 2**NODE_ADDR)
//  MEM_LAT      2    table read latency, cycles (1..3)
// PORTS
//  clk             in  1                  clock
//  RSTn            in  1                  async active-low reset
//  packet_in       in  LANES*PACKET_WIDTH lane i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//  data_valid_in   in  LANES              per-lane valid
//  node_in         in  LANES*NODE_WIDTH   current node per lane
//  matched_in      in  LANES              node_in is already a leaf
//  upd_valid       in  1                  table write strobe
//  upd_addr        in  $clog2(MEM_DEPTH)  write address
//  upd_data        in  NODE_WIDTH         write data
//  packet_out      out LANES*PACKET_WIDTH delayed header
//  data_valid_out  out LANES              delayed valid
//  node_out        out LANES*NODE_WIDTH   child node or passed-through leaf
//  matched_out     out LANES              delayed matched_in
//  addr_err_out    out LANES              child address >= MEM_DEPTH
// BEHAVIOUR
//  Bit-position field k: node[14+8*k -: BIT_WIDTH], k=0..EBITS-1. Mask: node[4+EBITS-1:4].
//  Per lane: e[k] = packet[pos_k] & mask[k]. Positions >= PACKET_WIDTH read 0.
//  addr = base + e, computed NODE_ADDR wide; carry discarded (wraps mod 2**NODE_ADDR).
//  Table read enable = data_valid_in & ~matched_in. No read for idle or matched lanes.
//  Latency L = MEM_LAT+1 cycles for every output, all lanes aligned. Throughput: 1 lookup per lane per cycle, no stall.
//  Output cycle, lane valid:
//   - matched   -> node_out = node_in delayed L.
//   - addr>=MEM_DEPTH -> node_out = 0, addr_err_out = 1.
//   - otherwise -> node_out = table[addr].
//  Lane invalid: node_out = 0, packet_out = 0, matched_out = 0, addr_err_out = 0.
//  Update: upd_valid writes table[upd_addr] at the clock edge. Write is ignored if upd_addr >= MEM_DEPTH.
//  Same-cycle read of the same address returns OLD data (read-first), unless the macro below is defined.
//  Several lanes reading one address in the same cycle is legal; each lane gets identical data.
//  Reset: every output and every pipeline register (valids, nodes, matched, err) goes to 0 asynchronously.
//   In-flight lookups are dropped. Table contents are not reset; they come from the init file or updates.
//   The first valid output appears L cycles after the first valid input following reset release.
// CONFIGURATION
//  TREE_LEVEL_WR_FWD_EN defined:
//   - a read that matches an update in the same cycle or any of the following MEM_LAT-1 cycles returns the newest upd_data;
//   - the youngest write wins.
//  Undefined: pure read-first RAM semantics, no forwarding logic.
// STRUCTURE
//  tree_pkg: node field offsets (FIRST_BIT=14, BIT_STRIDE=8, MASK_LSB=4), function ebit_index(packet,node,EBITS).
//  Sub-module tree_node_ram: 1W/1R, MEM_LAT registered read, optional init file.
//   One instance per lane; every instance shares the write port, giving identical replicas.
//  Per-lane generate loop holds the extract/add logic and an L-deep shift register for packet/valid/node/matched/err.
// TESTING
//  1. Reset, load table[i]=i<<20 for i=0..63. Lane0 node base=8, mask=111, header bits=101 (e=5), valid.
//     -> 3 cycles later node_out0=13<<20, valid_out0=1.
//  2. Lane1 matched_in=1, node_in=40'hABCDE_12345. -> node_out1=40'hABCDE_12345 after 3 cycles; table not read.
//  3. Mask=010, all header bits 1, base=60. -> reads 62. Base=63, mask=111, e=7. -> addr 70 >= 64: node_out=0, addr_err_out=1.
//  4. Both lanes read addr 13 while upd writes 13 with 40'h1. -> 40'h1 with TREE_LEVEL_WR_FWD_EN, old 13<<20 without.
//  5. Back-to-back valid every cycle on both lanes for 100 cycles vs scoreboard. -> zero mismatches, no gaps.
//  6. RSTn low for 1 cycle with 2 lookups in flight. -> all outputs 0 immediately; no stale valid after release.

Source files
------------

// File: rtl/tree_pkg.sv
// tree_pkg: node word field layout and header-bit extraction shared by tree level stages.
package tree_pkg;
  localparam int FIRST_BIT = 14;
  localparam int BIT_STRIDE = 8;
  localparam int MASK_LSB = 4;
  localparam int MAX_EBITS = 3;
  localparam int PKT_MAX = 256;
  localparam int NODE_MAX = 64;
  function automatic logic [MAX_EBITS-1:0] ebit_index(input logic [PKT_MAX-1:0] packet, input logic [NODE_MAX-1:0] node,
                                                     input int pw, input int ebits, input int bw);
    logic [MAX_EBITS-1:0] e;
    int pos;
    e = '0;
    for (int k = 0; k < MAX_EBITS; k++) begin
      pos = int'((node >> (FIRST_BIT + BIT_STRIDE * k + 1 - bw)) & ((64'd1 << bw) - 64'd1));
      e[k] = k < ebits && pos < pw && packet[pos[7:0]] && node[MASK_LSB + k];
    end
    return e;
  endfunction
endpackage

// File: rtl/tree_node_ram.sv
// tree_node_ram: 1W/1R node table replica with a MEM_LAT-deep registered read, read-first by default.
// TREE_LEVEL_WR_FWD_EN: writes landing while a read is in flight overwrite its data, youngest last.
module tree_node_ram #(
  parameter int NODE_WIDTH = 40,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_LAT = 2,
  parameter int AW = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NODE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [NODE_WIDTH-1:0] rdata
);
  logic [NODE_WIDTH-1:0] mem [MEM_DEPTH];
  logic [NODE_WIDTH-1:0] rd_q [MEM_LAT];
  logic wr_ok;
  if (2 ** AW > MEM_DEPTH) begin : g_wchk
    assign wr_ok = we && waddr < AW'(MEM_DEPTH);
  end else begin : g_wall
    assign wr_ok = we;
  end
  assign rdata = rd_q[MEM_LAT-1];
  always_ff @(posedge clk)
    if (wr_ok) mem[waddr] <= wdata;
`ifdef TREE_LEVEL_WR_FWD_EN
  logic [AW-1:0] ra_q [MEM_LAT];
  always_ff @(posedge clk) begin
    if (re) begin
      rd_q[0] <= wr_ok && waddr == raddr ? wdata : mem[raddr];
      ra_q[0] <= raddr;
    end
    for (int j = 1; j < MEM_LAT; j++) begin
      rd_q[j] <= wr_ok && waddr == ra_q[j-1] ? wdata : rd_q[j-1];
      ra_q[j] <= ra_q[j-1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (re) rd_q[0] <= mem[raddr];
    for (int j = 1; j < MEM_LAT; j++) rd_q[j] <= rd_q[j-1];
  end
`endif
endmodule

// File: rtl/tree_level_stage_mp.sv
// tree_level_stage_mp: one classification-tree level, LANES lookups per cycle over replicated node tables.
// TREE_LEVEL_WR_FWD_EN forwards table updates into reads that are still in flight.
module tree_level_stage_mp
  import tree_pkg::*;
#(
  parameter int PACKET_WIDTH = 104,
  parameter int NODE_WIDTH = 40,
  parameter int LANES = 2,
  parameter int EBITS = 3,
  parameter int BIT_WIDTH = 8,
  parameter int NODE_ADDR = 9,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic [LANES*PACKET_WIDTH-1:0] packet_in,
  input  logic [LANES-1:0]              data_valid_in,
  input  logic [LANES*NODE_WIDTH-1:0]   node_in,
  input  logic [LANES-1:0]              matched_in,
  input  logic                          upd_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0]  upd_addr,
  input  logic [NODE_WIDTH-1:0]         upd_data,
  output logic [LANES*PACKET_WIDTH-1:0] packet_out,
  output logic [LANES-1:0]              data_valid_out,
  output logic [LANES*NODE_WIDTH-1:0]   node_out,
  output logic [LANES-1:0]              matched_out,
  output logic [LANES-1:0]              addr_err_out
);
  localparam int AW = $clog2(MEM_DEPTH);
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    logic [PACKET_WIDTH-1:0] pkt, p_o;
    logic [NODE_WIDTH-1:0] node, dout, n_o;
    logic [MAX_EBITS-1:0] e;
    logic [NODE_ADDR-1:0] addr;
    logic v, m, err, re, v_o, m_o, err_o;
    logic [PACKET_WIDTH-1:0] p_q [MEM_LAT];
    logic [NODE_WIDTH-1:0] n_q [MEM_LAT];
    logic v_q [MEM_LAT];
    logic m_q [MEM_LAT];
    logic err_q [MEM_LAT];
    assign pkt = packet_in[i*PACKET_WIDTH +: PACKET_WIDTH];
    assign node = node_in[i*NODE_WIDTH +: NODE_WIDTH];
    assign v = data_valid_in[i];
    assign m = matched_in[i];
    assign e = ebit_index(PKT_MAX'(pkt), NODE_MAX'(node), PACKET_WIDTH, EBITS, BIT_WIDTH);
    assign addr = node[NODE_WIDTH-1 -: NODE_ADDR] + NODE_ADDR'(e[EBITS-1:0]);
    assign err = 32'(addr) >= MEM_DEPTH;
    assign re = v && !m && !err;
    tree_node_ram #(.NODE_WIDTH(NODE_WIDTH), .MEM_DEPTH(MEM_DEPTH), .MEM_LAT(MEM_LAT)) u_ram (
      .clk(clk), .we(upd_valid), .waddr(upd_addr), .wdata(upd_data),
      .re(re), .raddr(addr[AW-1:0]), .rdata(dout)
    );
    // Side-band is zeroed on entry so idle lanes carry nothing down the pipe.
    always_ff @(posedge clk or negedge RSTn)
      if (!RSTn) begin
        for (int j = 0; j < MEM_LAT; j++) begin
          p_q[j] <= '0;
          n_q[j] <= '0;
          v_q[j] <= 1'b0;
          m_q[j] <= 1'b0;
          err_q[j] <= 1'b0;
        end
        p_o <= '0;
        n_o <= '0;
        v_o <= 1'b0;
        m_o <= 1'b0;
        err_o <= 1'b0;
      end else begin
        p_q[0] <= v ? pkt : '0;
        n_q[0] <= v && m ? node : '0;
        v_q[0] <= v;
        m_q[0] <= v && m;
        err_q[0] <= v && !m && err;
        for (int j = 1; j < MEM_LAT; j++) begin
          p_q[j] <= p_q[j-1];
          n_q[j] <= n_q[j-1];
          v_q[j] <= v_q[j-1];
          m_q[j] <= m_q[j-1];
          err_q[j] <= err_q[j-1];
        end
        p_o <= p_q[MEM_LAT-1];
        v_o <= v_q[MEM_LAT-1];
        m_o <= m_q[MEM_LAT-1];
        err_o <= err_q[MEM_LAT-1];
        n_o <= m_q[MEM_LAT-1] ? n_q[MEM_LAT-1] : v_q[MEM_LAT-1] && !err_q[MEM_LAT-1] ? dout : '0;
      end
    assign packet_out[i*PACKET_WIDTH +: PACKET_WIDTH] = p_o;
    assign node_out[i*NODE_WIDTH +: NODE_WIDTH] = n_o;
    assign data_valid_out[i] = v_o;
    assign matched_out[i] = m_o;
    assign addr_err_out[i] = err_o;
  end
endmodule

// File: tb/tb_tree_level_stage_mp.sv
// tb_tree_level_stage_mp: randomized lookups and table updates against a table-level reference model.
module tb_tree_level_stage_mp;
  localparam int PW = 104, NW = 40, L = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2*PW-1:0] packet_in, packet_out;
  logic [2*NW-1:0] node_in, node_out;
  logic [1:0] data_valid_in, matched_in, data_valid_out, matched_out, addr_err_out;
  logic upd_valid;
  logic [5:0] upd_addr;
  logic [NW-1:0] upd_data;
  int checks = 0, errors = 0, vcnt;
  bit chk_en = 1'b0;

  tree_level_stage_mp dut (
    .clk(clk), .RSTn(rst_n), .packet_in(packet_in), .data_valid_in(data_valid_in), .node_in(node_in),
    .matched_in(matched_in), .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
    .packet_out(packet_out), .data_valid_out(data_valid_out), .node_out(node_out),
    .matched_out(matched_out), .addr_err_out(addr_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v, m, err;
    logic [PW-1:0] p;
    logic [NW-1:0] n, d;
    int a;
  } exp_t;
  logic [NW-1:0] mem_m [64];
  exp_t pipe [2][L];
  exp_t cx;

  function automatic exp_t lookup(bit v, bit m, logic [PW-1:0] p, logic [NW-1:0] n);
    exp_t x;
    int e, pos;
    x = '{default: '0};
    e = 0;
    x.v = v; x.m = m; x.p = p; x.n = n;
    for (int k = 0; k < 3; k++) begin
      pos = int'(n[14 + 8*k -: 8]);
      if (pos < PW && p[pos] === 1'b1 && n[4 + k]) e += 1 << k;
    end
    x.a = (int'(n[39:31]) + e) % 512;
    x.err = x.a >= 64;
    if (v && !m && !x.err) x.d = mem_m[x.a];
    return x;
  endfunction

  // Reference: each lookup sees the table as it stood before this edge's write, or with
  // forwarding, the table as it stands at the end of its MEM_LAT-cycle read window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) for (int a = 0; a < L; a++) pipe[l][a] = '{default: '0};
    end else begin
      for (int l = 0; l < 2; l++) begin
        for (int a = L - 1; a > 0; a--) pipe[l][a] = pipe[l][a-1];
        pipe[l][0] = lookup(data_valid_in[l], matched_in[l], packet_in[l*PW +: PW], node_in[l*NW +: NW]);
      end
      if (upd_valid) mem_m[upd_addr] = upd_data;
`ifdef TREE_LEVEL_WR_FWD_EN
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < L - 1; a++)
          if (pipe[l][a].v && !pipe[l][a].m && !pipe[l][a].err) pipe[l][a].d = mem_m[pipe[l][a].a];
`endif
    end
  end

  task automatic chk(string name, int lane, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d: got %h expected %h", name, lane, act, exp);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int l = 0; l < 2; l++) begin
        cx = pipe[l][L-1];
        chk("valid_out", l, 128'(data_valid_out[l]), 128'(cx.v));
        chk("matched_out", l, 128'(matched_out[l]), 128'(cx.v && cx.m));
        chk("addr_err_out", l, 128'(addr_err_out[l]), 128'(cx.v && !cx.m && cx.err));
        chk("packet_out", l, 128'(packet_out[l*PW +: PW]), 128'(cx.v ? cx.p : '0));
        chk("node_out", l, 128'(node_out[l*NW +: NW]), 128'(!cx.v ? '0 : cx.m ? cx.n : cx.err ? '0 : cx.d));
      end

  function automatic logic [NW-1:0] mk_node(int base, int p0, int p1, int p2, int mask);
    return {9'(base), 8'(p2), 8'(p1), 8'(p0), 3'(mask), 4'h0};
  endfunction

  task automatic drive(int l, bit v, bit m, logic [PW-1:0] p, logic [NW-1:0] n);
    data_valid_in[l] = v;
    matched_in[l] = m;
    packet_in[l*PW +: PW] = p;
    node_in[l*NW +: NW] = n;
  endtask

  task automatic idle();
    data_valid_in = '0;
    matched_in = '0;
    packet_in = '0;
    node_in = '0;
    upd_valid = 1'b0;
    upd_addr = '0;
    upd_data = '0;
  endtask

  task automatic rand_cycle(int vpct);
    for (int l = 0; l < 2; l++) begin
      bit v = $urandom_range(0, 99) < vpct;
      bit m = $urandom_range(0, 3) == 0;
      int b = ($urandom_range(0, 7) == 0) ? $urandom_range(58, 63) : $urandom_range(0, 15);
      logic [NW-1:0] n = mk_node(b, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
                                 $urandom_range(0, 7)) | NW'($urandom_range(0, 15));
      if (m) n = NW'({$urandom(), $urandom()});
      drive(l, v, m, PW'({$urandom(), $urandom(), $urandom(), $urandom()}), n);
    end
    upd_valid = $urandom_range(0, 2) == 0;
    upd_addr = 6'($urandom_range(0, 22));
    upd_data = NW'({$urandom(), $urandom()});
  endtask

  task automatic wait_out();
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
  endtask

  logic [PW-1:0] ones;

  initial begin
    ones = '1;
    idle();
    repeat (3) @(negedge clk);
    chk("reset_valid", 0, 128'(data_valid_out), 128'd0);
    chk("reset_node", 0, 128'(node_out), 128'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      upd_valid = 1'b1;
      upd_addr = 6'(i);
      upd_data = NW'(i) << 20;
    end
    @(negedge clk);
    idle();
    // Base 8 plus extracted 101, alongside a leaf on lane 1.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, (PW'(1) << 3) | (PW'(1) << 100), mk_node(8, 3, 10, 100, 7));
    drive(1, 1'b1, 1'b1, ones, 40'hABCDE_12345);
    wait_out();
    chk("t1_node", 0, 128'(node_out[NW-1:0]), 128'(40'd13 << 20));
    chk("t1_valid", 0, 128'(data_valid_out[0]), 128'd1);
    chk("t2_leaf", 1, 128'(node_out[2*NW-1:NW]), 128'h00_ABCDE_12345);
    chk("t2_matched", 1, 128'(matched_out[1]), 128'd1);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, ones, mk_node(60, 1, 2, 3, 3'b010));
    drive(1, 1'b1, 1'b0, ones, mk_node(63, 1, 2, 3, 7));
    wait_out();
    chk("t3_mask", 0, 128'(node_out[NW-1:0]), 128'(40'd62 << 20));
    chk("t3_err_node", 1, 128'(node_out[2*NW-1:NW]), 128'd0);
    chk("t3_err", 1, 128'(addr_err_out[1]), 128'd1);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, ones, mk_node(4, 200, 1, 2, 7));
    drive(1, 1'b1, 1'b0, ones, mk_node(4, 103, 104, 255, 7));
    wait_out();
    chk("t3_pos_oob", 0, 128'(node_out[NW-1:0]), 128'(40'd10 << 20));
    chk("t3_pos_edge", 1, 128'(node_out[2*NW-1:NW]), 128'(40'd5 << 20));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, '0, mk_node(13, 0, 0, 0, 0));
    drive(1, 1'b1, 1'b0, '0, mk_node(13, 0, 0, 0, 0));
    upd_valid = 1'b1;
    upd_addr = 6'd13;
    upd_data = 40'h1;
    wait_out();
`ifdef TREE_LEVEL_WR_FWD_EN
    chk("t4_same_cycle", 0, 128'(node_out[NW-1:0]), 128'h1);
    chk("t4_same_cycle", 1, 128'(node_out[2*NW-1:NW]), 128'h1);
`else
    chk("t4_same_cycle", 0, 128'(node_out[NW-1:0]), 128'(40'd13 << 20));
    chk("t4_same_cycle", 1, 128'(node_out[2*NW-1:NW]), 128'(40'd13 << 20));
`endif
    @(negedge clk);
    drive(0, 1'b1, 1'b0, '0, mk_node(20, 0, 0, 0, 0));
    @(negedge clk);
    idle();
    upd_valid = 1'b1;
    upd_addr = 6'd20;
    upd_data = 40'h2;
    @(negedge clk);
    idle();
    @(negedge clk);
`ifdef TREE_LEVEL_WR_FWD_EN
    chk("t4_next_cycle", 0, 128'(node_out[NW-1:0]), 128'h2);
`else
    chk("t4_next_cycle", 0, 128'(node_out[NW-1:0]), 128'(40'd20 << 20));
`endif
    vcnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vcnt += int'(data_valid_out[0]) + int'(data_valid_out[1]);
      rand_cycle(100);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vcnt += int'(data_valid_out[0]) + int'(data_valid_out[1]);
      idle();
    end
    chk("t5_valid_count", 0, 128'(vcnt), 128'd200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rand_cycle(100);
    end
    @(posedge clk);
    #1;
    chk("t6_pre_valid", 0, 128'(data_valid_out), 128'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 0, 128'(data_valid_out), 128'd0);
    chk("t6_rst_node", 0, 128'(node_out), 128'd0);
    chk("t6_rst_packet", 0, 128'(packet_out[PW-1:0]), 128'd0);
    chk("t6_rst_flags", 0, 128'({matched_out, addr_err_out}), 128'd0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_no_stale", 0, 128'(data_valid_out), 128'd0);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rand_cycle(75);
    end
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
